// File: rtl/modbus_rtu_frame_checker.sv
// Modbus RTU receive framer: silence-based frame delimiting, slave address
// filter, trailing CRC-16 check and CRC-stripped payload forwarding.
module modbus_rtu_frame_checker #(
    parameter int unsigned T15_CYCLES = 1719,
    parameter int unsigned T35_CYCLES = 4010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    input  logic [7:0] my_addr,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_first,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [2:0] err_code,
    output logic [8:0] frame_len
);
    localparam int unsigned   CW       = $clog2(T35_CYCLES + 1);
    localparam logic [CW-1:0] C_T15    = CW'(T15_CYCLES);
    localparam logic [CW-1:0] C_T35    = CW'(T35_CYCLES);
    localparam logic [CW-1:0] C_T35M1  = CW'(T35_CYCLES - 1);
    localparam logic [8:0]    LEN_MAX  = 9'd257;
    localparam logic [8:0]    LEN_LONG = 9'd256;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_CRC   = 3'd1;
    localparam logic [2:0] E_SHORT = 3'd2;
    localparam logic [2:0] E_LONG  = 3'd3;
    localparam logic [2:0] E_GAP   = 3'd4;
    localparam logic [2:0] E_RX    = 3'd5;
    localparam logic [2:0] E_ADDR  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RECV, S_DISCARD} state_t;

    state_t        r_state;
    logic [CW-1:0] r_c;
    logic [15:0]   r_crc;
    logic [8:0]    r_len;
    logic [2:0]    r_err;
    logic [7:0]    r_hold0;
    logic [7:0]    r_hold1;

    logic          w_c_reach;
    logic          w_gap;
    logic          w_addr_ok;
    logic [2:0]    w_byte_err;
    logic [15:0]   w_crc_run;
    logic [15:0]   w_crc_start;

    // One byte of the reflected Modbus CRC-16 (poly 0xA001).
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Per-byte qualifiers and the silence-reached event.
    always_comb begin
        w_c_reach   = !rx_valid && (r_c == C_T35M1);
        w_gap       = (r_c > C_T15) && (r_c < C_T35);
        w_addr_ok   = (rx_data == my_addr) || (rx_data == 8'h00);
        w_crc_run   = crc_byte(r_crc, rx_data);
        w_crc_start = crc_byte(16'hFFFF, rx_data);
        if (rx_err) begin
            w_byte_err = E_RX;
        end else if (w_gap) begin
            w_byte_err = E_GAP;
        end else if (r_len == LEN_LONG) begin
            w_byte_err = E_LONG;
        end else begin
            w_byte_err = E_NONE;
        end
    end

    // Line silence counter: cleared by any byte, saturates at the T3.5 limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0;
        end else if (rx_valid) begin
            r_c <= '0;
        end else if (r_c != C_T35) begin
            r_c <= r_c + CW'(1);
        end
    end

    // Frame state machine with registered payload and verdict outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_crc      <= 16'hFFFF;
            r_len      <= '0;
            r_err      <= E_NONE;
            r_hold0    <= '0;
            r_hold1    <= '0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            pl_first   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= E_NONE;
            frame_len  <= '0;
        end else begin
            pl_valid   <= 1'b0;
            pl_first   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= E_NONE;
            frame_len  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_c_reach) begin
                        r_state <= S_READY;
                    end
                end
                S_READY: begin
                    if (rx_valid) begin
                        r_crc   <= w_crc_start;
                        r_len   <= 9'd1;
                        r_hold0 <= rx_data;
                        if (rx_err) begin
                            r_err   <= E_RX;
                            r_state <= S_DISCARD;
                        end else if (!w_addr_ok) begin
                            r_err   <= E_ADDR;
                            r_state <= S_DISCARD;
                        end else begin
                            r_err   <= E_NONE;
                            r_state <= S_RECV;
                        end
                    end
                end
                S_RECV, S_DISCARD: begin
                    if (rx_valid) begin
                        r_crc <= w_crc_run;
                        if (r_len != LEN_MAX) begin
                            r_len <= r_len + 9'd1;
                        end
                        if (r_state == S_RECV) begin
                            if (w_byte_err != E_NONE) begin
                                r_err   <= w_byte_err;
                                r_state <= S_DISCARD;
                            end else begin
                                r_hold0 <= rx_data;
                                r_hold1 <= r_hold0;
                                if (r_len >= 9'd2) begin
                                    pl_valid <= 1'b1;
                                    pl_data  <= r_hold1;
                                    pl_first <= (r_len == 9'd2);
                                end
                            end
                        end
                    end else if (w_c_reach) begin
                        frame_done <= 1'b1;
                        frame_len  <= r_len;
                        r_state    <= S_READY;
                        if (r_err != E_NONE) begin
                            err_code <= r_err;
                        end else if (r_len < 9'd4) begin
                            err_code <= E_SHORT;
                        end else if (r_crc != 16'h0000) begin
                            err_code <= E_CRC;
                        end else begin
                            frame_ok <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/modbus_rtu_frame_checker.md
# modbus_rtu_frame_checker

Receive-side Modbus RTU framer. It sits between the UART byte receiver and the request decoder. It detects frame boundaries from line silence, filters frames by slave address, and checks the trailing Modbus CRC-16. It forwards the payload with the two CRC bytes stripped and reports a per-frame verdict.

## Interface
Parameters:
- T15_CYCLES, 1719: maximum allowed clk cycles between bytes inside a frame (1.5 character times).
- T35_CYCLES, 4010: clk cycles of silence that close a frame (3.5 character times); must exceed T15_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_err  in  1  one-cycle strobe, UART parity/framing error on the current byte.
- my_addr  in  8  own slave address (1..247), static.
- pl_data  out  8  payload byte (address byte through last data byte).
- pl_valid  out  1  one-cycle strobe for pl_data.
- pl_first  out  1  high with pl_valid on the address byte.
- frame_done  out  1  one-cycle end-of-frame strobe.
- frame_ok  out  1  valid with frame_done; 1 means commit the payload.
- err_code  out  3  valid with frame_done: 0 none, 1 CRC, 2 short, 3 long, 4 gap, 5 rx_err, 6 address.
- frame_len  out  9  valid with frame_done; byte count including CRC, saturates at 257.

## Operation
- Silence counter `c`:
  - cleared on any rx_valid cycle.
  - otherwise increments each cycle, saturating at T35_CYCLES.
  - in the checks below, `c` means the value before update in the rx_valid cycle.
- States:
  - IDLE: after reset. Bytes are dropped and restart `c`. Go to READY when `c` reaches T35_CYCLES.
  - READY: the first rx_valid starts a frame and goes to RECV.
  - RECV: accumulating bytes.
  - DISCARD: the frame is in error. Bytes are counted, no payload is output, and the first error is kept.
- Frame close: in RECV or DISCARD, when `c` reaches T35_CYCLES, assert frame_done and return to READY.
- CRC:
  - Modbus CRC-16: reflected poly 0xA001, init 0xFFFF, one byte per rx_valid cycle, covering all bytes including the two CRC bytes.
  - Init 0xFFFF is reloaded at frame start.
  - The frame is good iff the residue is 0x0000.
- Address:
  - Byte 0 must equal my_addr or 0x00 (broadcast).
  - Otherwise err 6 and DISCARD; no pl_valid for that frame.
- Errors; the first one latched wins and enters DISCARD:
  - rx_err on any frame byte: err 5.
  - byte with T15_CYCLES < c < T35_CYCLES: err 4.
  - 257th byte: err 3.
- Checks at close, only if no error is latched:
  - len < 4: err 2.
  - otherwise residue ≠ 0: err 1.
  - otherwise frame_ok = 1.
- Payload delay line:
  - Two-byte hold register.
  - On frame byte n ≥ 2, byte n−2 is emitted.
  - The last two bytes (CRC) are never emitted.
  - Payload of a frame later found bad has already been emitted; the consumer commits only on frame_ok.

## Timing
- Reset values: all outputs 0; state IDLE, `c` = 0, CRC 0xFFFF.
- Reset mid-frame: the frame is abandoned with no frame_done, and T35 silence is required again.
- pl_valid is registered and occurs one cycle after the rx_valid of byte n+2.
- frame_done is high in the cycle `c` first equals T35_CYCLES, i.e. T35_CYCLES cycles after the last rx_valid.
- rx_valid in the frame_done cycle:
  - frame_done reports the old frame.
  - the byte starts a new frame: CRC reinitialised, counters reset, pl_first pending.
- A byte arriving with c ≥ T35_CYCLES in READY starts a frame normally.
- frame_ok, err_code and frame_len are zero outside frame_done.
- Back-to-back rx_valid on consecutive cycles is supported.

## Test plan
- Use T15_CYCLES = 20 and T35_CYCLES = 40 for all scenarios.
- Good frame: after 40 idle cycles, send 01 03 00 00 00 01 84 0A, my_addr = 01 → pl bytes 01 03 00 00 00 01 (pl_first on 01); frame_done with frame_ok = 1, err 0, len 8, exactly 40 cycles after the last byte.
- Corrupted CRC: last byte 0B → 6 pl bytes; frame_ok = 0, err 1, len 8.
- Address filter: send the same frame with my_addr = 02 → no pl_valid; err 6. Repeat with address 00 and a valid CRC → frame_ok = 1.
- Gap and short frame:
  - Byte 3 delayed 25 cycles → err 4, no further pl_valid.
  - Frame 01 03 00 → err 2, len 3.
- Simultaneous events: a new frame's byte arrives in the frame_done cycle → old verdict reported, and the new frame verifies OK. rx_err on byte 2 → err 5.
- Reset: rst_n low mid-frame → outputs 0. Bytes sent with less than 40 cycles of silence after reset are dropped with no frame_done.
